// File: rtl/sdpram_burst_reader.sv
// sdpram_burst_reader
// Read-side master for a simple dual-port RAM. It takes a burst command
// (start address and length) and drives the RAM read port. It absorbs the
// RAM's one-cycle read latency, then streams the words out on a
// valid/ready interface that carries a last-beat marker.
// A 4-entry output FIFO decouples the RAM from downstream backpressure.
// Reads are only issued when there is guaranteed room for their data.

module sdpram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  // burst command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WORD_DEPTH-1:0] cmd_addr,
  input  logic [WORD_DEPTH:0]   cmd_len,
  // RAM read port
  output logic                  ram_enb,
  output logic [WORD_DEPTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  // output stream
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  // status
  output logic                  busy,
  output logic                  done
);

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;
  localparam int LEN_W      = WORD_DEPTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // control state
  state_t                state_q;
  logic [WORD_DEPTH-1:0] addr_q;        // next address to read
  logic [WORD_DEPTH-1:0] ram_addrb_q;
  logic                  ram_enb_q;     // read presented to the RAM this cycle
  logic                  cap_q;         // RAM data for last cycle's read is on doutb now
  logic [LEN_W-1:0]      issue_rem_q;   // reads still to be issued
  logic [LEN_W-1:0]      beats_rem_q;   // beats still to be handed downstream

  // output FIFO
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;

  // datapath helpers
  logic [CNT_W-1:0]      in_flight;
  logic [CNT_W-1:0]      occupancy;
  logic                  cmd_fire;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  drain_done;

  // Reads whose data has not reached the FIFO yet: one sitting on the RAM
  // port and one whose data is on doutb waiting to be written.
  assign in_flight = CNT_W'(ram_enb_q) + CNT_W'(cap_q);
  assign occupancy = fifo_count_q + in_flight;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Only issue while the FIFO plus everything in flight still leaves a slot,
  // so the FIFO can never overflow whatever the consumer does.
  assign issue = (state_q == ST_READ) && (issue_rem_q != '0)
                 && (occupancy < CNT_W'(FIFO_DEPTH));

  // doutb is only meaningful the cycle after a read; otherwise it is ignored.
  assign push = cap_q;

  assign m_valid  = (fifo_count_q != '0);
  assign m_data   = fifo_mem_q[rd_ptr_q];
  assign m_last   = m_valid && (beats_rem_q == LEN_W'(1));
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && m_last;

  // A zero-length burst reaches DRAIN with nothing to send and finishes at once.
  assign drain_done = (state_q == ST_DRAIN) && (last_pop || (beats_rem_q == '0));
  assign done       = drain_done;

  assign ram_enb   = ram_enb_q;
  assign ram_addrb = ram_addrb_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // FIFO storage and pointers; reset empties it so nothing stale is ever shown
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= ram_doutb;
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Burst FSM with the registered RAM port, read-issue and beat counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      ram_addrb_q <= '0;
      ram_enb_q   <= 1'b0;
      cap_q       <= 1'b0;
      issue_rem_q <= '0;
      beats_rem_q <= '0;
    end else begin
      ram_enb_q <= issue;
      cap_q     <= ram_enb_q;

      if (issue) begin
        ram_addrb_q <= addr_q;
        addr_q      <= addr_q + WORD_DEPTH'(1);   // wraps around the RAM
        issue_rem_q <= issue_rem_q - LEN_W'(1);
      end

      if (cmd_fire) begin
        beats_rem_q <= cmd_len;
      end else if (pop) begin
        beats_rem_q <= beats_rem_q - LEN_W'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            addr_q      <= cmd_addr;
            issue_rem_q <= cmd_len;
            state_q     <= (cmd_len != '0) ? ST_READ : ST_DRAIN;
          end
        end
        ST_READ: begin
          if (issue && (issue_rem_q == LEN_W'(1))) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
